// File: rtl/jk_arb_pkg.sv
// -----------------------------------------------------------------------------
// jk_arb_pkg: command encoding and FSM state type for jk_cmd_arbiter.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package jk_arb_pkg;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_RST  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TGL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/jk_ff.sv
// -----------------------------------------------------------------------------
// jk_ff: JK flip-flop with asynchronous active-low reset.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module jk_ff
  import jk_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        CMD_HOLD: q <= q;
        CMD_RST:  q <= 1'b0;
        CMD_SET:  q <= 1'b1;
        default:  q <= ~q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/jk_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// jk_cmd_arbiter: round-robin arbiter applying one {j,k} command per grant to a
// shared JK flip-flop. Define JK_ARB_TOGGLE_CNT_EN to add toggle_cnt. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module jk_cmd_arbiter
  import jk_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] cmd,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               j,
  output logic               k,
  output logic               q,
  output logic               busy
`ifdef JK_ARB_TOGGLE_CNT_EN
  ,
  output logic [7:0]         toggle_cnt
`endif
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [PTR_W:0] NR = (PTR_W+1)'(N_REQ);

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] pick;
  logic [PTR_W-1:0] ptr_nxt;
  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W:0]   inc;

  // Search upward from ptr with wrap; the first requester seen wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    for (int o = 0; o < N_REQ; o++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(o);
      if (sum >= NR) sum = sum - NR;
      if (!found && req[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[PTR_W-1:0];
      end
    end
    inc     = {1'b0, pick} + (PTR_W+1)'(1);
    ptr_nxt = (inc == NR) ? '0 : inc[PTR_W-1:0];
  end

  // j/k double as the captured command; later cmd changes cannot reach the FF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      win   <= '0;
      gnt   <= '0;
      done  <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= '0;
          if (found) begin
            win   <= pick;
            ptr   <= ptr_nxt;
            gnt   <= N_REQ'(1) << pick;
            j     <= cmd[{pick, 1'b1}];
            k     <= cmd[{pick, 1'b0}];
            state <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          gnt   <= '0;
          j     <= 1'b0;
          k     <= 1'b0;
          done  <= N_REQ'(1) << win;
          state <= ST_ACK;
        end
        ST_ACK: begin
          done  <= '0;
          state <= ST_IDLE;
        end
        default: begin
          gnt   <= '0;
          done  <= '0;
          j     <= 1'b0;
          k     <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

  jk_ff u_jk_ff (
    .clk (clk),
    .rst (rst),
    .j   (j),
    .k   (k),
    .q   (q)
  );

`ifdef JK_ARB_TOGGLE_CNT_EN
  logic q_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_d        <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      q_d <= q;
      if ((q != q_d) && (toggle_cnt != 8'hFF)) toggle_cnt <= toggle_cnt + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_jk_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_jk_cmd_arbiter: directed and randomized checks against a behavioural model.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_jk_cmd_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] cmd = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           j;
  logic           k;
  logic           q;
  logic           busy;
`ifdef JK_ARB_TOGGLE_CNT_EN
  logic [7:0]     toggle_cnt;
`endif

  int   checks = 0;
  int   errors = 0;
  int   m_ptr  = 0;
  logic m_q    = 1'b0;

  always #5 clk = ~clk;

  jk_cmd_arbiter #(.N_REQ(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .cmd  (cmd),
    .gnt  (gnt),
    .done (done),
    .j    (j),
    .k    (k),
    .q    (q),
    .busy (busy)
`ifdef JK_ARB_TOGGLE_CNT_EN
    ,
    .toggle_cnt (toggle_cnt)
`endif
  );

  function automatic int rr_pick(input int p, input logic [N-1:0] r);
    for (int o = 0; o < N; o++) if (r[(p + o) % N]) return (p + o) % N;
    return -1;
  endfunction

  function automatic logic next_q(input logic cur, input logic [1:0] c);
    case (c)
      2'b00:   return cur;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~cur;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    @(posedge clk); #1;
    rst   = 1'b1;
    m_q   = 1'b0;
    m_ptr = 0;
  endtask

  // Drives one request set and samples the APPLY, ACK and following IDLE cycles.
  task automatic run_txn(input logic [N-1:0] r, input logic [2*N-1:0] c,
                         input logic [N-1:0] mr, input logic [2*N-1:0] mc,
                         output logic [N-1:0] g_ap, output logic [1:0] jk_ap,
                         output logic b_ap, output logic [N-1:0] d_ack,
                         output logic q_ack, output logic [N-1:0] g_ack,
                         output logic b_idle);
    req = r; cmd = c;
    @(posedge clk); #1;
    g_ap = gnt; jk_ap = {j, k}; b_ap = busy;
    req = mr; cmd = mc;
    @(posedge clk); #1;
    d_ack = done; q_ack = q; g_ack = gnt;
    @(posedge clk); #1;
    b_idle = busy;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt, done, j, k, q, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b done=%b j=%b k=%b q=%b busy=%b expected all 0",
               gnt, done, j, k, q, busy);
    end
    req = 4'b0001; cmd = 8'b0000_0010;
    @(posedge clk); #1;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL reset_pre_apply_gnt: got %b expected 0001", gnt);
    end
    rst = 1'b0; #1;
    checks++;
    if ({gnt, done, j, k, q, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_apply: got gnt=%b done=%b j=%b k=%b q=%b busy=%b expected all 0",
               gnt, done, j, k, q, busy);
    end
    req = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== '0 || q !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done: cycle %0d got done=%b q=%b busy=%b expected 0,0,0",
                 i, done, q, busy);
      end
    end
  endtask

  task automatic test_single();
    logic [N-1:0] g_ap, d_ack, g_ack;
    logic [1:0]   jk_ap;
    logic         b_ap, q_ack, b_idle;
    do_reset();
    run_txn(4'b0001, 8'b0000_0010, '0, '0, g_ap, jk_ap, b_ap, d_ack, q_ack, g_ack, b_idle);
    checks++;
    if (g_ap !== 4'b0001 || jk_ap !== 2'b10 || b_ap !== 1'b1) begin
      errors++;
      $display("FAIL single_apply: got gnt=%b jk=%b busy=%b expected 0001 10 1", g_ap, jk_ap, b_ap);
    end
    checks++;
    if (d_ack !== 4'b0001 || q_ack !== 1'b1 || g_ack !== '0) begin
      errors++;
      $display("FAIL single_ack: got done=%b q=%b gnt=%b expected 0001 1 0000", d_ack, q_ack, g_ack);
    end
    checks++;
    if (b_idle !== 1'b0 || done !== '0) begin
      errors++;
      $display("FAIL single_idle: got busy=%b done=%b expected 0 0000", b_idle, done);
    end
  endtask

  task automatic test_toggle_reset();
    logic [N-1:0] g_ap, d_ack, g_ack;
    logic [1:0]   jk_ap;
    logic         b_ap, q_ack, b_idle;
    logic [1:0]   seq_cmd [3] = '{2'b11, 2'b11, 2'b01};
    logic         seq_q   [3] = '{1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_txn(4'b0001, {6'b0, seq_cmd[i]}, 4'b0001, {6'b0, seq_cmd[i]},
              g_ap, jk_ap, b_ap, d_ack, q_ack, g_ack, b_idle);
      checks++;
      if (q_ack !== seq_q[i] || d_ack !== 4'b0001) begin
        errors++;
        $display("FAIL toggle_reset_seq: step %0d got q=%b done=%b expected q=%b done=0001",
                 i, q_ack, d_ack, seq_q[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g_ap, d_ack, g_ack;
    logic [1:0]   jk_ap;
    logic         b_ap, q_ack, b_idle;
    logic [N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic         exp_q;
    do_reset();
    exp_q = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 8'hFF, 4'b1111, 8'hFF, g_ap, jk_ap, b_ap, d_ack, q_ack, g_ack, b_idle);
      exp_q = ~exp_q;
      checks++;
      if (g_ap !== exp_g[i] || d_ack !== exp_g[i] || q_ack !== exp_q) begin
        errors++;
        $display("FAIL round_robin: txn %0d got gnt=%b done=%b q=%b expected gnt=done=%b q=%b",
                 i, g_ap, d_ack, q_ack, exp_g[i], exp_q);
      end
    end
  endtask

  task automatic test_mid_change();
    logic [N-1:0] g_ap, d_ack, g_ack;
    logic [1:0]   jk_ap;
    logic         b_ap, q_ack, b_idle;
    do_reset();
    run_txn(4'b0001, 8'b0000_0010, 4'b0110, 8'b0101_0101,
            g_ap, jk_ap, b_ap, d_ack, q_ack, g_ack, b_idle);
    checks++;
    if (q_ack !== 1'b1 || d_ack !== 4'b0001) begin
      errors++;
      $display("FAIL mid_change: got q=%b done=%b expected q=1 done=0001", q_ack, d_ack);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]   g_ap, d_ack, g_ack, r, eg;
    logic [2*N-1:0] c;
    logic [1:0]     jk_ap, ec;
    logic           b_ap, q_ack, b_idle;
    int             w;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      r = N'($urandom_range(0, 15));
      c = (2*N)'($urandom);
      w = rr_pick(m_ptr, r);
      if (w < 0) begin
        req = r; cmd = c;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || gnt !== '0) begin
          errors++;
          $display("FAIL random_idle: iter %0d got busy=%b gnt=%b expected 0 0000", i, busy, gnt);
        end
      end else begin
        ec    = c[2*w +: 2];
        eg    = N'(1) << w;
        m_q   = next_q(m_q, ec);
        m_ptr = (w + 1) % N;
        run_txn(r, c, N'($urandom), (2*N)'($urandom),
                g_ap, jk_ap, b_ap, d_ack, q_ack, g_ack, b_idle);
        checks++;
        if (g_ap !== eg || jk_ap !== ec || b_ap !== 1'b1) begin
          errors++;
          $display("FAIL random_apply: iter %0d got gnt=%b jk=%b busy=%b expected %b %b 1",
                   i, g_ap, jk_ap, b_ap, eg, ec);
        end
        checks++;
        if (d_ack !== eg || q_ack !== m_q || g_ack !== '0 || b_idle !== 1'b0) begin
          errors++;
          $display("FAIL random_ack: iter %0d got done=%b q=%b gnt=%b busy_after=%b expected %b %b 0000 0",
                   i, d_ack, q_ack, g_ack, b_idle, eg, m_q);
        end
      end
    end
  endtask

`ifdef JK_ARB_TOGGLE_CNT_EN
  task automatic test_toggle_cnt();
    logic [N-1:0] g_ap, d_ack, g_ack;
    logic [1:0]   jk_ap;
    logic         b_ap, q_ack, b_idle;
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      run_txn(4'b0001, 8'h03, 4'b0001, 8'h03, g_ap, jk_ap, b_ap, d_ack, q_ack, g_ack, b_idle);
      if (i == 10 || i == 300) begin
        checks++;
        if (toggle_cnt !== 8'((i > 255) ? 255 : i)) begin
          errors++;
          $display("FAIL toggle_cnt: after %0d toggles got %0d expected %0d",
                   i, toggle_cnt, (i > 255) ? 255 : i);
        end
      end
    end
    do_reset();
    checks++;
    if (toggle_cnt !== 8'd0) begin
      errors++;
      $display("FAIL toggle_cnt_reset: got %0d expected 0", toggle_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_toggle_reset();
    test_round_robin();
    test_mid_change();
    test_random();
`ifdef JK_ARB_TOGGLE_CNT_EN
    test_toggle_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jk_cmd_arbiter.md
JK_CMD_ARBITER -- requirements
Module: jk_cmd_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters (2..8).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  N_REQ  per-requester request level.
REQ-005 Port: cmd  input  2*N_REQ  per-requester command, {j,k} pair at bits [2i+1:2i].
REQ-006 Port: gnt  output  N_REQ  one-hot grant, high only in APPLY.
REQ-007 Port: done  output  N_REQ  one-hot completion pulse, high only in ACK.
REQ-008 Port: j, k  output  1 each  drive to the shared JK flip-flop; 0 outside APPLY.
REQ-009 Port: q  output  1  shared flip-flop state.
REQ-010 Port: busy  output  1  high when FSM is not IDLE.

Function
REQ-011 Command encoding SHALL be 00 hold, 01 reset (q<=0), 10 set (q<=1), 11 toggle (q<=~q).
REQ-012 FSM SHALL have states IDLE, APPLY and ACK.
REQ-013 IDLE: if any req bit is high, register the round-robin winner index and its cmd, then go to APPLY; otherwise stay in IDLE.
REQ-014 Round-robin SHALL search from pointer ptr upward with wrap-around; the first req bit found high wins.
REQ-015 ptr SHALL load winner+1 (mod N_REQ) on the IDLE->APPLY transition.
REQ-016 APPLY: gnt[winner]=1 and {j,k}=registered cmd for exactly one cycle; the flip-flop samples at the end of APPLY; next state is ACK.
REQ-017 ACK: done[winner]=1 for exactly one cycle, q SHALL already show the new value, and the next state is IDLE.
REQ-018 Latency SHALL be: req sampled in IDLE at edge E, gnt in cycle E+1, q updated and done in cycle E+2, next arbitration at E+3.
REQ-019 cmd and req changes during APPLY/ACK SHALL be ignored; a transaction always completes once started.
REQ-020 A req still high in IDLE after its done SHALL count as a new request and compete normally.
REQ-021 A hold command SHALL still run the full IDLE/APPLY/ACK sequence and produce done, with q unchanged.
REQ-022 With all N_REQ requesting continuously, each requester SHALL be served exactly once per N_REQ transactions.

Reset
REQ-023 rst low SHALL immediately force: FSM=IDLE, ptr=0, q=0, gnt=0, done=0, j=k=0, busy=0, and the optional counter=0.
REQ-024 Reset asserted mid-transaction SHALL abort it with no done pulse; arbitration restarts from ptr=0 after release.

Configuration
REQ-025 Macro JK_ARB_TOGGLE_CNT_EN SHALL add output toggle_cnt (8 bits), which counts cycles in which q changed value and saturates at 255.
REQ-026 Without JK_ARB_TOGGLE_CNT_EN the port and counter logic SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package jk_arb_pkg SHALL hold the command encoding constants (CMD_HOLD, CMD_RST, CMD_SET, CMD_TGL) and the FSM state typedef.
REQ-028 The shared flip-flop SHALL be sub-module jk_ff (clk, rst async active-low, j, k, q), instantiated once.

Verification
REQ-029 Reset: rst=0 mid-APPLY with cmd=10 -> q=0, gnt=0, done=0, busy=0 immediately; no done after release.
REQ-030 Single requester: req=0001, cmd[1:0]=10 -> gnt=0001 at E+1, q=1 and done=0001 at E+2.
REQ-031 Toggle then reset: req0 toggles twice, then sends 01 -> q sequence 1,0,0, with one done per transaction.
REQ-032 Round-robin: req=1111 held high with all cmd=11 -> gnt order 0001,0010,0100,1000,0001; q alternates every transaction.
REQ-033 Mid-transaction change: cmd[1:0] changed from 10 to 01 during APPLY -> q=1 (captured cmd used).
REQ-034 With JK_ARB_TOGGLE_CNT_EN: 300 toggle transactions -> toggle_cnt=255; after reset -> 0.
